// File: rtl/serial_packet_demux_pkg.sv
// Shared types and helpers for the bit-serial packet demultiplexer.
// The state encoding is fixed at 2 bits so it can be observed on the debug port.
package serial_packet_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PORT = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } spd_state_t;

    localparam int DEF_PORT_W = 2;
    localparam int DEF_LEN_W  = 4;

    function automatic int spd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit-counter width that can index either header field.
    localparam int CNT_W = spd_max(DEF_PORT_W, DEF_LEN_W);

endpackage

// File: rtl/serial_packet_demux_if.sv
// Bus between the serial line sampler (master) and the packet demultiplexer (slave).
interface serial_packet_demux_if
    import serial_packet_demux_pkg::*;
#(
    parameter int PORT_W = 2,
    parameter int NUM_CH = 4
);
    // No back-pressure: clken qualifies serIn on the clock edge it is high;
    // serOutValid/done/err are one-clk pulses that a sink must take when they appear.
    logic              clken;
    logic              serIn;
    logic [NUM_CH-1:0] serOut;
    logic [NUM_CH-1:0] serOutValid;
    logic [PORT_W-1:0] portId;
    logic              busy;
    logic              done;
    logic              err;
    spd_state_t        dbg_state;

    modport master (
        output clken, serIn,
        input  serOut, serOutValid, portId, busy, done, err, dbg_state
    );

    modport slave (
        input  clken, serIn,
        output serOut, serOutValid, portId, busy, done, err, dbg_state
    );

endinterface

// File: rtl/serial_packet_demux_field.sv
// MSB-first field shifter used for the port-id and length headers.
// o_full flags the strobe whose bit completes the field, so o_value is usable in that same cycle.
module spd_field_shifter
    import serial_packet_demux_pkg::*;
#(
    parameter int W      = 2,
    parameter int FCNT_W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clken,
    input  logic         i_clr,
    input  logic         i_shift,
    input  logic         i_bit,
    output logic [W-1:0] o_value,
    output logic         o_full
);

    logic [W-1:0]      r_data;
    logic [FCNT_W-1:0] r_cnt;
    logic [W:0]        w_cat;

    assign w_cat   = {r_data, i_bit};
    assign o_value = w_cat[W-1:0];
    assign o_full  = i_clken && i_shift && (r_cnt == FCNT_W'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clken) begin
            if (i_clr) begin
                r_data <= '0;
                r_cnt  <= '0;
            end else if (i_shift) begin
                r_data <= o_value;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_packet_demux.sv
// Bit-serial packet receiver: start bit, port id, length, then payload steered to one channel.
// Header fields are collected by two spd_field_shifter instances; FSM and steering live here.
module serial_packet_demux
    import serial_packet_demux_pkg::*;
#(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4,
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_packet_demux_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_PORT = 2'(ST_PORT);
    localparam logic [1:0] S_LEN  = 2'(ST_LEN);
    localparam logic [1:0] S_DATA = 2'(ST_DATA);

    localparam int              FIELD_CNT_W = spd_max(PORT_W, LEN_W);
    localparam logic [PORT_W:0] NUM_CH_L    = (PORT_W + 1)'(NUM_CH);

    logic [1:0]        r_state;
    logic [PORT_W-1:0] r_port_id;
    logic [LEN_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_ser_out;
    logic [NUM_CH-1:0] r_ser_valid;
    logic              r_done;
    logic              r_err;

    logic [PORT_W-1:0] w_port_value;
    logic              w_port_full;
    logic [LEN_W-1:0]  w_len_value;
    logic              w_len_full;
    logic              w_port_ok;
    logic              w_in_idle;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_port_ok = ({1'b0, r_port_id} < NUM_CH_L);

    // Both counters restart on every idle strobe so a new start bit begins a clean header.
    spd_field_shifter #(
        .W      (PORT_W),
        .FCNT_W (FIELD_CNT_W)
    ) u_port_field (
        .clk     (clk),
        .rst     (rst),
        .i_clken (bus.clken),
        .i_clr   (w_in_idle),
        .i_shift (r_state == S_PORT),
        .i_bit   (bus.serIn),
        .o_value (w_port_value),
        .o_full  (w_port_full)
    );

    spd_field_shifter #(
        .W      (LEN_W),
        .FCNT_W (FIELD_CNT_W)
    ) u_len_field (
        .clk     (clk),
        .rst     (rst),
        .i_clken (bus.clken),
        .i_clr   (w_in_idle),
        .i_shift (r_state == S_LEN),
        .i_bit   (bus.serIn),
        .o_value (w_len_value),
        .o_full  (w_len_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_port_id   <= '0;
            r_cnt       <= '0;
            r_ser_out   <= '0;
            r_ser_valid <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ser_valid <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            if (bus.clken) begin
                case (r_state)
                    S_IDLE: begin
                        if (!bus.serIn) r_state <= S_PORT;
                    end
                    S_PORT: begin
                        if (w_port_full) begin
                            r_port_id <= w_port_value;
                            r_state   <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_len_full) begin
                            if (w_len_value == '0) begin
                                r_state <= S_IDLE;
                                r_done  <= w_port_ok;
                                r_err   <= !w_port_ok;
                            end else begin
                                r_cnt   <= w_len_value;
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        r_cnt <= r_cnt - 1'b1;
                        // Invalid ids match no channel: payload is consumed silently.
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            if (w_port_ok && (r_port_id == PORT_W'(ch))) begin
                                r_ser_out[ch]   <= bus.serIn;
                                r_ser_valid[ch] <= 1'b1;
                            end
                        end
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_IDLE;
                            r_done  <= w_port_ok;
                            r_err   <= !w_port_ok;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.serOut      = r_ser_out;
    assign bus.serOutValid = r_ser_valid;
    assign bus.portId      = r_port_id;
    assign bus.busy        = !w_in_idle;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.dbg_state   = spd_state_t'(r_state);

endmodule
